// File: rtl/mldsa_pkg.sv
// rtl/mldsa_pkg.sv - ML-DSA shared constants, Barrett parameters and FSM state type
package mldsa_pkg;
  localparam int Q              = 8380417;
  localparam int N              = 256;
  localparam int WORDS_PER_POLY = 64;
  localparam int COEFF_WIDTH    = 24;
  localparam int COEFF_PER_WORD = 4;
  localparam int WORD_COEFF     = COEFF_WIDTH * COEFF_PER_WORD;

  // m = floor(2^48 / q): for 46-bit products the quotient estimate is at most one short
  localparam int BARRETT_K = 48;
  localparam int BARRETT_M = 33587228;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/mod_mul_q.sv
// rtl/mod_mul_q.sv - two-stage pipelined lane multiply with Barrett reduction mod q
module mod_mul_q
  import mldsa_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [COEFF_WIDTH-1:0] a,
  input  logic [COEFF_WIDTH-1:0] b,
  output logic [22:0]            r
);
  // bit 23 of a lane carries no coefficient information
  localparam logic [COEFF_WIDTH-1:0] LANE_MASK = 24'h7f_ffff;
  localparam logic [24:0]            Q25       = 25'(Q);

  logic [45:0] p;
  logic [23:0] q_hat;
  logic [46:0] q_mul;
  logic [24:0] r_est;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p <= '0;
    else        p <= 46'(a & LANE_MASK) * 46'(b & LANE_MASK);
  end

  // r_est lands in [0, 2q) so a single conditional subtract makes it canonical
  always_comb begin
    q_hat = 24'((72'(p) * 72'(BARRETT_M)) >> BARRETT_K);
    q_mul = 47'(q_hat) * 47'(Q);
    r_est = 25'(47'(p) - q_mul);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r <= '0;
    else        r <= (r_est >= Q25) ? 23'(r_est - Q25) : r_est[22:0];
  end
endmodule

// File: rtl/matvec_ntt_acc.sv
// rtl/matvec_ntt_acc.sv - NTT-domain matrix-vector product t = A o s with per-lane mod-q accumulation
module matvec_ntt_acc
  import mldsa_pkg::*;
#(
  parameter int K                    = 8,
  parameter int L                    = 7,
  parameter int NTT_ADDR_WIDTH       = 12,
  parameter int MATRIX_A_BASE_OFFSET = 0,
  parameter int S_BASE_OFFSET        = 0,
  parameter int T_BASE_OFFSET        = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [NTT_ADDR_WIDTH-1:0] addr_matA,
  input  logic [WORD_COEFF-1:0]     dout_matA,
  output logic [NTT_ADDR_WIDTH-1:0] addr_s,
  input  logic [WORD_COEFF-1:0]     dout_s,
  output logic                      we_t,
  output logic [NTT_ADDR_WIDTH-1:0] addr_t,
  output logic [WORD_COEFF-1:0]     din_t
);
  localparam int AW = NTT_ADDR_WIDTH;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int LW = (L > 1) ? $clog2(L) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);
  localparam logic [LW-1:0] L_LAST = LW'(L - 1);
  localparam logic [5:0]    W_LAST = 6'(WORDS_PER_POLY - 1);
  localparam logic [23:0]   Q24    = 24'(Q);

  function automatic logic [AW-1:0] a_addr(input int kk, input int ll, input int ww);
    return AW'(MATRIX_A_BASE_OFFSET + (kk * L + ll) * WORDS_PER_POLY + ww);
  endfunction

  function automatic logic [AW-1:0] s_addr(input int ll, input int ww);
    return AW'(S_BASE_OFFSET + ll * WORDS_PER_POLY + ww);
  endfunction

  state_t state, state_nx;
  logic [KW-1:0] k, k_nx;
  logic [5:0]    w, w_nx;
  logic [LW-1:0] l, l_nx;
  logic          last_pair;
  // v*: slot valid, f*: first column (l == 0), e*: last column (l == L-1)
  logic          v0, v1, v2, v3, f1, f2, f3, e1, e2, e3;
  logic [AW-1:0] wr_idx;
  logic [COEFF_PER_WORD-1:0][22:0] r_lane, acc, acc_nx;
  logic [WORD_COEFF-1:0]           din_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_RUN;
      ST_RUN:   if (last_pair) state_nx = ST_DRAIN;
      ST_DRAIN: if (!(v1 || v2 || v3)) state_nx = ST_DONE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_RUN) || (state == ST_DRAIN);
    done = (state == ST_DONE);
  end

  always_comb begin
    k_nx = k;
    w_nx = w;
    l_nx = l + LW'(1);
    if (l == L_LAST) begin
      l_nx = '0;
      w_nx = w + 6'd1;
      if (w == W_LAST) begin
        w_nx = '0;
        k_nx = k + KW'(1);
      end
    end
  end

  assign last_pair = (k == K_LAST) && (w == W_LAST) && (l == L_LAST);

  // counters name the pair presented on the address outputs this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= '0; w <= '0; l <= '0; v0 <= 1'b0;
      addr_matA <= '0; addr_s <= '0;
    end else if (state == ST_IDLE && start) begin
      k <= '0; w <= '0; l <= '0; v0 <= 1'b1;
      addr_matA <= a_addr(0, 0, 0);
      addr_s    <= s_addr(0, 0);
    end else if (state == ST_RUN) begin
      if (last_pair) begin
        v0 <= 1'b0;
      end else begin
        k <= k_nx; w <= w_nx; l <= l_nx;
        addr_matA <= a_addr(int'(k_nx), int'(l_nx), int'(w_nx));
        addr_s    <= s_addr(int'(l_nx), int'(w_nx));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {v1, v2, v3, f1, f2, f3, e1, e2, e3} <= '0;
    end else begin
      v1 <= v0;  f1 <= (l == '0); e1 <= (l == L_LAST);
      v2 <= v1;  f2 <= f1;        e2 <= e1;
      v3 <= v2;  f3 <= f2;        e3 <= e2;
    end
  end

  for (genvar j = 0; j < COEFF_PER_WORD; j++) begin : g_lane
    mod_mul_q u_mul (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (dout_matA[COEFF_WIDTH*j +: COEFF_WIDTH]),
      .b     (dout_s[COEFF_WIDTH*j +: COEFF_WIDTH]),
      .r     (r_lane[j])
    );
  end

  always_comb begin : acc_next
    logic [23:0] sum;
    sum    = '0;
    acc_nx = '0;
    din_nx = '0;
    for (int j = 0; j < COEFF_PER_WORD; j++) begin
      sum = {1'b0, acc[j]} + {1'b0, r_lane[j]};
      if (f3)              acc_nx[j] = r_lane[j];
      else if (sum >= Q24) acc_nx[j] = 23'(sum - Q24);
      else                 acc_nx[j] = sum[22:0];
      din_nx[COEFF_WIDTH*j +: COEFF_WIDTH] = {1'b0, acc_nx[j]};
    end
  end

  // t writes are issued in k-major, w-minor order, so a running index is the word offset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0; wr_idx <= '0; we_t <= 1'b0; addr_t <= '0; din_t <= '0;
    end else begin
      we_t <= 1'b0;
      if (state == ST_IDLE && start) wr_idx <= '0;
      if (v3) begin
        acc <= acc_nx;
        if (e3) begin
          we_t   <= 1'b1;
          addr_t <= AW'(T_BASE_OFFSET) + wr_idx;
          din_t  <= din_nx;
          wr_idx <= wr_idx + AW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_matvec_ntt_acc.sv
// tb/tb_matvec_ntt_acc.sv - scoreboard bench for matvec_ntt_acc
module tb_matvec_ntt_acc;
  localparam int K = 8, L = 7, AW = 12, Q = 8380417, NW = K * 64, NP = K * L * 64;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [95:0]   data;
  } wr_t;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic busy, done, we_t;
  logic [AW-1:0] addr_matA, addr_s, addr_t;
  logic [95:0]   dout_matA, dout_s, din_t;

  logic [95:0] mem_a [4096];
  logic [95:0] mem_s [4096];

  wr_t exp_q[$], obs_q[$];
  logic [AW-1:0] obs_a[$], obs_s[$];
  int vectors = 0, miscompares = 0;
  int done_cyc, done_cnt, first_wr, last_wr;
  logic busy_at1, busy_at_done;
  logic s_we, s_busy, s_done;
  logic [AW-1:0] s_am, s_as, s_at;
  logic [95:0] s_din;

  matvec_ntt_acc dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .addr_matA(addr_matA), .dout_matA(dout_matA), .addr_s(addr_s), .dout_s(dout_s),
    .we_t(we_t), .addr_t(addr_t), .din_t(din_t)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    dout_matA <= mem_a[addr_matA];
    dout_s    <= mem_s[addr_s];
  end

  task automatic fill(input int mode);
    logic [23:0] v;
    for (int i = 0; i < NP; i++)
      for (int j = 0; j < 4; j++) begin
        case (mode)
          0: v = 24'd0;
          1: v = 24'd1;
          2, 3: v = 24'(Q - 1);
          default: v = 24'($urandom_range(0, Q - 1)) | (24'($urandom_range(0, 1)) << 23);
        endcase
        mem_a[i][24*j +: 24] = v;
      end
    for (int i = 0; i < L * 64; i++)
      for (int j = 0; j < 4; j++) begin
        case (mode)
          0: v = 24'($urandom_range(0, Q - 1));
          1: v = 24'(i / 64 + 1);
          2: v = 24'(Q - 1);
          3: v = 24'd1;
          default: v = 24'($urandom_range(0, Q - 1)) | (24'($urandom_range(0, 1)) << 23);
        endcase
        mem_s[i][24*j +: 24] = v;
      end
  endtask

  task automatic push_expected();
    logic [95:0] d;
    longint a, s, acc;
    for (int k = 0; k < K; k++)
      for (int w = 0; w < 64; w++) begin
        d = '0;
        for (int j = 0; j < 4; j++) begin
          acc = 0;
          for (int l = 0; l < L; l++) begin
            a = longint'(mem_a[k*L*64 + l*64 + w][24*j +: 23]);
            s = longint'(mem_s[l*64 + w][24*j +: 23]);
            acc = (acc + (a * s) % Q) % Q;
          end
          d[24*j +: 24] = 24'(acc);
        end
        exp_q.push_back({AW'(k * 64 + w), d});
      end
  endtask

  task automatic run_collect(input int rst_at, input int restart_at);
    obs_q.delete(); obs_a.delete(); obs_s.delete();
    done_cyc = 0; done_cnt = 0; first_wr = 0; last_wr = 0;
    busy_at1 = 1'b0; busy_at_done = 1'b1;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 5000; cyc++) begin
      @(negedge clk);
      start = (cyc == restart_at);
      if (cyc == rst_at) begin
        rst_n = 1'b0;
        #1;
        s_we = we_t; s_busy = busy; s_done = done;
        s_am = addr_matA; s_as = addr_s; s_at = addr_t; s_din = din_t;
        break;
      end
      if (cyc == 1) busy_at1 = busy;
      if (cyc <= NP) begin
        obs_a.push_back(addr_matA);
        obs_s.push_back(addr_s);
      end
      if (we_t) begin
        obs_q.push_back({addr_t, din_t});
        if (first_wr == 0) first_wr = cyc;
        last_wr = cyc;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc = cyc;
          busy_at_done = busy;
        end
      end
      if (done_cyc != 0 && cyc >= done_cyc + 3) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, we_t} !== 3'b000) begin
      miscompares++; $display("FAIL reset_ctrl got %b expected 000", {busy, done, we_t});
    end
    vectors++;
    if ({addr_matA, addr_s, addr_t} !== '0) begin
      miscompares++; $display("FAIL reset_addr got %h/%h/%h expected 0", addr_matA, addr_s, addr_t);
    end
    vectors++;
    if (din_t !== '0) begin
      miscompares++; $display("FAIL reset_din got %h expected 0", din_t);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    vectors++;
    if ({busy, done, we_t} !== 3'b000) begin
      miscompares++; $display("FAIL idle_ctrl got %b expected 000", {busy, done, we_t});
    end
  endtask

  task automatic test_zero_timing();
    wr_t e, o;
    fill(0); push_expected(); run_collect(0, 0);
    vectors++;
    if (first_wr != 11) begin miscompares++; $display("FAIL first_write_cycle got %0d expected 11", first_wr); end
    vectors++;
    if (last_wr != 3588) begin miscompares++; $display("FAIL last_write_cycle got %0d expected 3588", last_wr); end
    vectors++;
    if (done_cyc != 3589 || done_cnt != 1) begin
      miscompares++; $display("FAIL done_cycle got %0d (pulses %0d) expected 3589 (1)", done_cyc, done_cnt);
    end
    vectors++;
    if (busy_at1 !== 1'b1 || busy_at_done !== 1'b0) begin
      miscompares++; $display("FAIL busy_window got %b/%b expected 1/0", busy_at1, busy_at_done);
    end
    vectors++;
    if (obs_q.size() != NW) begin miscompares++; $display("FAIL zero_write_count got %0d expected %0d", obs_q.size(), NW); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front(); else o = '1;
      vectors++;
      if (o !== e) begin
        miscompares++; $display("FAIL zero_write got addr=%h data=%h expected addr=%h data=%h", o.addr, o.data, e.addr, e.data);
      end
    end
  endtask

  task automatic test_patterns();
    wr_t e, o;
    for (int mode = 1; mode <= 3; mode++) begin
      fill(mode); push_expected(); run_collect(0, 0);
      vectors++;
      if (obs_q.size() != NW || done_cyc != 3589) begin
        miscompares++; $display("FAIL pattern%0d_run got writes=%0d done=%0d expected %0d/3589", mode, obs_q.size(), done_cyc, NW);
      end
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (obs_q.size() != 0) o = obs_q.pop_front(); else o = '1;
        vectors++;
        if (o !== e) begin
          miscompares++; $display("FAIL pattern%0d_write got addr=%h data=%h expected addr=%h data=%h", mode, o.addr, o.data, e.addr, e.data);
        end
      end
    end
  endtask

  task automatic test_reset_midrun();
    wr_t e, o;
    int stray;
    fill(2); run_collect(1000, 0);
    vectors++;
    if ({s_we, s_busy, s_done} !== 3'b000) begin
      miscompares++; $display("FAIL midrun_reset_ctrl got %b expected 000", {s_we, s_busy, s_done});
    end
    vectors++;
    if ({s_am, s_as, s_at} !== '0 || s_din !== '0) begin
      miscompares++; $display("FAIL midrun_reset_data got %h/%h/%h/%h expected 0", s_am, s_as, s_at, s_din);
    end
    stray = 0;
    repeat (2) @(negedge clk) if (we_t) stray++;
    rst_n = 1'b1;
    repeat (20) @(negedge clk) if (we_t || busy) stray++;
    vectors++;
    if (stray != 0) begin miscompares++; $display("FAIL no_resume got %0d active cycles expected 0", stray); end
    fill(3); push_expected(); run_collect(0, 0);
    vectors++;
    if (obs_q.size() != NW || done_cyc != 3589) begin
      miscompares++; $display("FAIL rerun got writes=%0d done=%0d expected %0d/3589", obs_q.size(), done_cyc, NW);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front(); else o = '1;
      vectors++;
      if (o !== e) begin
        miscompares++; $display("FAIL rerun_write got addr=%h data=%h expected addr=%h data=%h", o.addr, o.data, e.addr, e.data);
      end
    end
  endtask

  task automatic test_restart_ignored();
    wr_t e, o;
    logic [AW-1:0] ea, es;
    int kk, ww, ll;
    fill(4); push_expected(); run_collect(0, 500);
    vectors++;
    if (done_cnt != 1 || done_cyc != 3589 || obs_q.size() != NW) begin
      miscompares++; $display("FAIL restart_run got pulses=%0d done=%0d writes=%0d expected 1/3589/%0d", done_cnt, done_cyc, obs_q.size(), NW);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front(); else o = '1;
      vectors++;
      if (o !== e) begin
        miscompares++; $display("FAIL restart_write got addr=%h data=%h expected addr=%h data=%h", o.addr, o.data, e.addr, e.data);
      end
    end
    vectors++;
    if (obs_a.size() != NP) begin miscompares++; $display("FAIL addr_samples got %0d expected %0d", obs_a.size(), NP); end
    for (int n = 0; n < obs_a.size(); n++) begin
      kk = n / (L * 64); ww = (n / L) % 64; ll = n % L;
      ea = AW'(kk * L * 64 + ll * 64 + ww);
      es = AW'(ll * 64 + ww);
      vectors++;
      if (obs_a[n] !== ea || obs_s[n] !== es) begin
        miscompares++; $display("FAIL read_addr pair %0d got %h/%h expected %h/%h", n, obs_a[n], obs_s[n], ea, es);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_timing();
    test_patterns();
    test_reset_midrun();
    test_restart_ignored();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
